// File: rtl/fpnew_pipe_lanes.sv
// Multi-lane elastic pipeline: per-lane gated data regs, shared mask/tag/aux, flush, occupancy.
// Optional one-entry output skid register, enabled by defining FPNEW_PIPE_LANES_SKID_EN.
module fpnew_pipe_lanes #(
    parameter int unsigned NumLanes    = 1,
    parameter int unsigned LaneWidth   = 64,
    parameter int unsigned NumPipeRegs = 2,
    parameter int unsigned TagWidth    = 1,
    parameter int unsigned AuxWidth    = 1,
`ifdef FPNEW_PIPE_LANES_SKID_EN
    localparam int unsigned CntWidth   = $clog2(NumPipeRegs + 3)
`else
    localparam int unsigned CntWidth   = $clog2(NumPipeRegs + 2)
`endif
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumLanes*LaneWidth-1:0] lane_data_i,
    input  logic [NumLanes-1:0]           lane_mask_i,
    input  logic [TagWidth-1:0]           tag_i,
    input  logic [AuxWidth-1:0]           aux_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          flush_i,
    output logic [NumLanes*LaneWidth-1:0] lane_data_o,
    output logic [NumLanes-1:0]           lane_mask_o,
    output logic [TagWidth-1:0]           tag_o,
    output logic [AuxWidth-1:0]           aux_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          busy_o,
    output logic [CntWidth-1:0]           occupancy_o
);

    localparam int unsigned DataWidth = NumLanes * LaneWidth;

    if (NumPipeRegs == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_i, flush_i};
        assign lane_data_o = lane_data_i;
        assign lane_mask_o = lane_mask_i;
        assign tag_o       = tag_i;
        assign aux_o       = aux_i;
        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign busy_o      = in_valid_i;
        assign occupancy_o = '0;
    end else begin : g_pipe
        localparam int unsigned Last = NumPipeRegs - 1;

        logic [NumPipeRegs-1:0] valid_q, valid_d, s_valid;
        logic [NumPipeRegs:0]   rdy;
        logic                   last_rdy;
        logic [DataWidth-1:0]   data_q [NumPipeRegs];
        logic [DataWidth-1:0]   data_d [NumPipeRegs];
        logic [DataWidth-1:0]   s_data [NumPipeRegs];
        logic [NumLanes-1:0]    mask_q [NumPipeRegs];
        logic [NumLanes-1:0]    mask_d [NumPipeRegs];
        logic [NumLanes-1:0]    s_mask [NumPipeRegs];
        logic [TagWidth-1:0]    tag_q  [NumPipeRegs];
        logic [TagWidth-1:0]    tag_d  [NumPipeRegs];
        logic [TagWidth-1:0]    s_tag  [NumPipeRegs];
        logic [AuxWidth-1:0]    aux_q  [NumPipeRegs];
        logic [AuxWidth-1:0]    aux_d  [NumPipeRegs];
        logic [AuxWidth-1:0]    s_aux  [NumPipeRegs];
        logic [CntWidth-1:0]    occupancy_q, occupancy_d;

        // Stage i is fed by the input ports (i = 0) or by stage i-1.
        always_comb begin
            s_valid[0] = in_valid_i;
            s_data[0]  = lane_data_i;
            s_mask[0]  = lane_mask_i;
            s_tag[0]   = tag_i;
            s_aux[0]   = aux_i;
            for (int i = 1; i < int'(NumPipeRegs); i++) begin
                s_valid[i] = valid_q[i-1];
                s_data[i]  = data_q[i-1];
                s_mask[i]  = mask_q[i-1];
                s_tag[i]   = tag_q[i-1];
                s_aux[i]   = aux_q[i-1];
            end
        end

        // Ready ripples backwards; an empty stage is always ready so bubbles get squeezed out.
        always_comb begin
            logic r;
            r                = last_rdy;
            rdy[NumPipeRegs] = r;
            for (int i = int'(NumPipeRegs) - 1; i >= 0; i--) begin
                r      = r | ~valid_q[i];
                rdy[i] = r;
            end
        end

        always_comb begin
            for (int i = 0; i < int'(NumPipeRegs); i++) begin
                valid_d[i] = rdy[i] ? s_valid[i] : valid_q[i];
                data_d[i]  = data_q[i];
                mask_d[i]  = mask_q[i];
                tag_d[i]   = tag_q[i];
                aux_d[i]   = aux_q[i];
                if (rdy[i] && s_valid[i]) begin
                    mask_d[i] = s_mask[i];
                    tag_d[i]  = s_tag[i];
                    aux_d[i]  = s_aux[i];
                    for (int k = 0; k < int'(NumLanes); k++) begin
                        if (s_mask[i][k]) begin
                            data_d[i][k*LaneWidth +: LaneWidth] = s_data[i][k*LaneWidth +: LaneWidth];
                        end
                    end
                end
                if (flush_i) valid_d[i] = 1'b0;
            end
        end

`ifdef FPNEW_PIPE_LANES_SKID_EN
        logic                 skid_valid_q, skid_valid_d;
        logic [DataWidth-1:0] skid_data_q, skid_data_d;
        logic [NumLanes-1:0]  skid_mask_q, skid_mask_d;
        logic [TagWidth-1:0]  skid_tag_q, skid_tag_d;
        logic [AuxWidth-1:0]  skid_aux_q, skid_aux_d;

        // Skid catches the last-stage item when downstream stalls, cutting the ready path.
        always_comb begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            skid_mask_d  = skid_mask_q;
            skid_tag_d   = skid_tag_q;
            skid_aux_d   = skid_aux_q;
            if (skid_valid_q) begin
                if (out_ready_i) skid_valid_d = 1'b0;
            end else if (valid_q[Last] && !out_ready_i) begin
                skid_valid_d = 1'b1;
                skid_data_d  = data_q[Last];
                skid_mask_d  = mask_q[Last];
                skid_tag_d   = tag_q[Last];
                skid_aux_d   = aux_q[Last];
            end
            if (flush_i) skid_valid_d = 1'b0;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
                skid_mask_q  <= '0;
                skid_tag_q   <= '0;
                skid_aux_q   <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
                skid_mask_q  <= skid_mask_d;
                skid_tag_q   <= skid_tag_d;
                skid_aux_q   <= skid_aux_d;
            end
        end

        assign last_rdy    = ~skid_valid_q;
        assign out_valid_o = skid_valid_q | valid_q[Last];
        assign lane_data_o = skid_valid_q ? skid_data_q : data_q[Last];
        assign lane_mask_o = skid_valid_q ? skid_mask_q : mask_q[Last];
        assign tag_o       = skid_valid_q ? skid_tag_q  : tag_q[Last];
        assign aux_o       = skid_valid_q ? skid_aux_q  : aux_q[Last];
        assign busy_o      = in_valid_i | (|valid_q) | skid_valid_q;
`else
        assign last_rdy    = out_ready_i;
        assign out_valid_o = valid_q[Last];
        assign lane_data_o = data_q[Last];
        assign lane_mask_o = mask_q[Last];
        assign tag_o       = tag_q[Last];
        assign aux_o       = aux_q[Last];
        assign busy_o      = in_valid_i | (|valid_q);
`endif

        always_comb begin
            occupancy_d = '0;
            for (int i = 0; i < int'(NumPipeRegs); i++) begin
                occupancy_d = occupancy_d + CntWidth'(valid_d[i]);
            end
`ifdef FPNEW_PIPE_LANES_SKID_EN
            occupancy_d = occupancy_d + CntWidth'(skid_valid_d);
`endif
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid_q     <= '0;
                occupancy_q <= '0;
                for (int i = 0; i < int'(NumPipeRegs); i++) begin
                    data_q[i] <= '0;
                    mask_q[i] <= '0;
                    tag_q[i]  <= '0;
                    aux_q[i]  <= '0;
                end
            end else begin
                valid_q     <= valid_d;
                occupancy_q <= occupancy_d;
                for (int i = 0; i < int'(NumPipeRegs); i++) begin
                    data_q[i] <= data_d[i];
                    mask_q[i] <= mask_d[i];
                    tag_q[i]  <= tag_d[i];
                    aux_q[i]  <= aux_d[i];
                end
            end
        end

        assign in_ready_o  = rdy[0];
        assign occupancy_o = occupancy_q;
    end

endmodule

// File: tb/tb_fpnew_pipe_lanes.sv
// Directed bench for fpnew_pipe_lanes: 4 lanes x 16 bits, two stages, 4-bit tag, 2-bit aux.
module tb_fpnew_pipe_lanes;

    localparam int unsigned NL = 4;
    localparam int unsigned LW = 16;
    localparam int unsigned NR = 2;
    localparam int unsigned TW = 4;
    localparam int unsigned AW = 2;
`ifdef FPNEW_PIPE_LANES_SKID_EN
    localparam int unsigned CW  = 3;
    localparam int          Cap = 3;
`else
    localparam int unsigned CW  = 2;
    localparam int          Cap = 2;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NL*LW-1:0]  lane_data_i;
    logic [NL-1:0]     lane_mask_i;
    logic [TW-1:0]     tag_i;
    logic [AW-1:0]     aux_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              flush_i;
    logic [NL*LW-1:0]  lane_data_o;
    logic [NL-1:0]     lane_mask_o;
    logic [TW-1:0]     tag_o;
    logic [AW-1:0]     aux_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              busy_o;
    logic [CW-1:0]     occupancy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    fpnew_pipe_lanes #(
        .NumLanes   (NL),
        .LaneWidth  (LW),
        .NumPipeRegs(NR),
        .TagWidth   (TW),
        .AuxWidth   (AW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .lane_data_i(lane_data_i),
        .lane_mask_i(lane_mask_i),
        .tag_i      (tag_i),
        .aux_i      (aux_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .flush_i    (flush_i),
        .lane_data_o(lane_data_o),
        .lane_mask_o(lane_mask_o),
        .tag_o      (tag_o),
        .aux_o      (aux_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o),
        .occupancy_o(occupancy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input int t, input logic [NL-1:0] m,
                         input logic [NL*LW-1:0] d, input int a);
        in_valid_i  = v;
        tag_i       = TW'(t);
        lane_mask_i = m;
        lane_data_i = d;
        aux_i       = AW'(a);
    endtask

    function automatic logic [NL*LW-1:0] mk_data(input int n);
        logic [NL*LW-1:0] d;
        for (int k = 0; k < int'(NL); k++) d[k*LW +: LW] = LW'(k * 4096 + n);
        return d;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int nxt;
        int exp_tag;

        rst_i = 1'b1;
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b0, 0, '0, '0, 0);
        tick();
        tick();
        rst_i = 1'b0;

        // reset state
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_occupancy", 64'(occupancy_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_busy_idle", 64'(busy_o), 64'd0);
        in_valid_i = 1'b1;
        #1;
        chk("rst_busy_in", 64'(busy_o), 64'd1);
        in_valid_i = 1'b0;

        // streaming, two-cycle latency
        for (int c = 0; c < 11; c++) begin
            chk("stream_valid", 64'(out_valid_o), 64'(c >= 2 && c < 10));
            chk("stream_occ", 64'(occupancy_o), 64'(int'(c >= 1 && c < 9) + int'(c >= 2 && c < 10)));
            if (c >= 2 && c < 10) begin
                chk("stream_tag", 64'(tag_o), 64'(c - 2));
                chk("stream_data", 64'(lane_data_o), 64'(mk_data(c - 2)));
                chk("stream_aux", 64'(aux_o), 64'((c - 2) % 4));
            end
            if (c < 8) drive(1'b1, c, 4'hF, mk_data(c), c);
            else in_valid_i = 1'b0;
            tick();
        end

        // backpressure: fill until ready drops
        out_ready_i = 1'b0;
        acc = 0;
        nxt = 8;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, nxt, 4'hF, mk_data(nxt), nxt);
            #1;
            if (in_ready_o) begin
                acc++;
                nxt++;
            end
            tick();
        end
        chk("bp_accepted", 64'(acc), 64'(Cap));
        chk("bp_in_ready", 64'(in_ready_o), 64'd0);
        chk("bp_occ", 64'(occupancy_o), 64'(Cap));
        chk("bp_head_tag", 64'(tag_o), 64'd8);

        // release: every tag 8..11 exits once, in order
        out_ready_i = 1'b1;
        exp_tag = 8;
        for (int c = 0; c < 20 && exp_tag < 12; c++) begin
            if (nxt < 12) drive(1'b1, nxt, 4'hF, mk_data(nxt), nxt);
            else in_valid_i = 1'b0;
            #1;
            if (out_valid_o) begin
                chk("bp_order", 64'(tag_o), 64'(exp_tag));
                chk("bp_data", 64'(lane_data_o), 64'(mk_data(exp_tag)));
                exp_tag++;
            end
            if (in_valid_i && in_ready_o) nxt++;
            tick();
        end
        in_valid_i = 1'b0;
        chk("bp_all_out", 64'(exp_tag), 64'd12);
        chk("bp_drained_valid", 64'(out_valid_o), 64'd0);
        chk("bp_drained_occ", 64'(occupancy_o), 64'd0);

        // lane mask gating
        drive(1'b1, 1, 4'hF, 64'h4444_3333_2222_1111, 1);
        tick();
        drive(1'b1, 2, 4'b0101, 64'hFFFF_BBBB_FFFF_AAAA, 2);
        tick();
        chk("mask_a_valid", 64'(out_valid_o), 64'd1);
        chk("mask_a_data", 64'(lane_data_o), 64'h4444_3333_2222_1111);
        drive(1'b1, 3, 4'b0000, 64'h5555_6666_7777_8888, 3);
        tick();
        chk("mask_b_tag", 64'(tag_o), 64'd2);
        chk("mask_b_data", 64'(lane_data_o), 64'h4444_BBBB_2222_AAAA);
        chk("mask_b_mask", 64'(lane_mask_o), 64'b0101);
        chk("mask_b_aux", 64'(aux_o), 64'd2);
        in_valid_i = 1'b0;
        tick();
        chk("mask_zero_valid", 64'(out_valid_o), 64'd1);
        chk("mask_zero_tag", 64'(tag_o), 64'd3);
        chk("mask_zero_mask", 64'(lane_mask_o), 64'd0);
        chk("mask_zero_data", 64'(lane_data_o), 64'h4444_BBBB_2222_AAAA);
        tick();
        chk("mask_end_valid", 64'(out_valid_o), 64'd0);

        // flush with two items in flight and a new item offered
        out_ready_i = 1'b0;
        drive(1'b1, 13, 4'hF, mk_data(13), 1);
        tick();
        drive(1'b1, 14, 4'hF, mk_data(14), 2);
        tick();
        chk("flush_pre_occ", 64'(occupancy_o), 64'd2);
        chk("flush_pre_tag", 64'(tag_o), 64'd13);
        drive(1'b1, 15, 4'hF, mk_data(15), 3);
        flush_i = 1'b1;
        #1;
        chk("flush_busy", 64'(busy_o), 64'd1);
        tick();
        flush_i = 1'b0;
        chk("flush_occ", 64'(occupancy_o), 64'd0);
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        chk("flush_busy_in", 64'(busy_o), 64'd1);
        in_valid_i = 1'b0;
        #1;
        chk("flush_busy_idle", 64'(busy_o), 64'd0);
        out_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("flush_no_leak", 64'(out_valid_o), 64'd0);
            tick();
        end

        // reset while full and stalled
        out_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, c, 4'hF, mk_data(c + 1), c);
            tick();
        end
        chk("mid_full_occ", 64'(occupancy_o), 64'(Cap));
        chk("mid_full_ready", 64'(in_ready_o), 64'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_occ", 64'(occupancy_o), 64'd0);
        chk("mid_rst_ready", 64'(in_ready_o), 64'd1);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_data", 64'(lane_data_o), 64'd0);
        chk("mid_rst_tag", 64'(tag_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
